// File: rtl/seg_uart_pkg.sv
// rtl/seg_uart_pkg.sv - shared types and defaults for the UART command receiver
package seg_uart_pkg;

  // Receiver frame states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  // 50 MHz clock, 19200 baud
  localparam int BAUD_DIV_DEF = 2604;

  // Command FIFO entries, power of two
  localparam int DEPTH_DEF = 4;

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - show-ahead command FIFO with wrap-bit pointers
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_pop;
  logic         do_push;

  // Extra MSB on each pointer separates full from empty when the indices match
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  // A pop on an empty FIFO is ignored; a push on a full FIFO is accepted only
  // when a pop frees the head slot in the same cycle
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout = mem[rptr[AW-1:0]];

  // Pointer update; the natural wrap of AW+1 bits gives modulo 2*DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty masks them
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_cmd_rcv.sv
// rtl/uart_cmd_rcv.sv - 8N1 UART receiver feeding a command FIFO
module uart_cmd_rcv
  import seg_uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF,
  parameter int DEPTH    = DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       rd,
  output logic       rdy,
  output logic [7:0] rx_data,
  output logic       frm_err,
  output logic       ovrflw
);

  localparam int CW = $clog2(BAUD_DIV);
  // Counter expires at zero, so a load of N-1 spans N clocks
  localparam logic [CW-1:0] FULL_LD = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LD = CW'(BAUD_DIV / 2 - 1);

  logic            rx_meta;
  logic            rx_s;
  logic [1:0]      sync_fill;
  logic            armed_q;
  logic            armed_d;
  rx_state_e       state_q;
  rx_state_e       state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [2:0]      bit_q;
  logic [2:0]      bit_d;
  logic [7:0]      shreg_q;
  logic [7:0]      shreg_d;
  logic            expired;
  logic            push_req;
  logic            ferr_req;
  logic            fifo_full;
  logic            fifo_empty;
  logic [7:0]      fifo_dout;
  logic            frm_err_q;
  logic            ovrflw_q;

  // Two-flop synchroniser preset high; sync_fill marks when rx_s carries a real sample
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      sync_fill <= 2'b00;
    end else begin
      rx_meta   <= RX;
      rx_s      <= rx_meta;
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  assign expired = (cnt_q == '0);

  // Frame sequencing: start detect, mid-bit sampling, stop check
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    armed_d  = armed_q;
    push_req = 1'b0;
    ferr_req = 1'b0;

    // A start bit is only honoured after the line has been seen idle high,
    // so a line held low across reset or a framing error cannot start a frame
    if (sync_fill[1] && rx_s) armed_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (armed_q && !rx_s) begin
          cnt_d   = HALF_LD;
          state_d = START;
        end
      end
      START: begin
        if (expired) begin
          if (!rx_s) begin
            cnt_d   = FULL_LD;
            bit_d   = 3'd0;
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (expired) begin
          shreg_d = {rx_s, shreg_q[7:1]};
          cnt_d   = FULL_LD;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (expired) begin
          if (rx_s) begin
            push_req = 1'b1;
          end else begin
            ferr_req = 1'b1;
            armed_d  = 1'b0;
          end
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Receiver state and datapath registers, plus registered status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= 3'd0;
      shreg_q   <= 8'h00;
      armed_q   <= 1'b0;
      frm_err_q <= 1'b0;
      ovrflw_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      armed_q   <= armed_d;
      frm_err_q <= ferr_req;
      // Full implies non-empty, so a simultaneous rd always makes room
      ovrflw_q  <= push_req && fifo_full && !rd;
    end
  end

  cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (rd),
    .din   (shreg_q),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rdy     = !fifo_empty;
  assign rx_data = fifo_empty ? 8'h00 : fifo_dout;
  assign frm_err = frm_err_q;
  assign ovrflw  = ovrflw_q;

endmodule

// File: tb/tb_uart_cmd_rcv.sv
// tb/tb_uart_cmd_rcv.sv - directed table-driven bench for uart_cmd_rcv
module tb_uart_cmd_rcv;

  localparam int FAST_DIV = 16;
  localparam int SLOW_DIV = 2604;

  logic       clk;
  logic       rst;
  logic       rx_fast;
  logic       rx_slow;
  logic       rd_fast_drv;
  logic       rd_fast;
  logic       rd_slow;
  logic       pop_on_push;
  logic       rdy_f, rdy_s;
  logic [7:0] data_f, data_s;
  logic       ferr_f, ferr_s;
  logic       ovr_f, ovr_s;

  int total;
  int passed;
  int ferr_f_cyc;
  int ferr_s_cyc;
  int ovr_f_cyc;
  int base_ferr;
  int base_ovr;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_rdy;
    logic [7:0] exp_data;
    int         exp_ferr;
  } vec_t;

  vec_t tbl [7];

  // Pops exactly on the push cycle when pop_on_push is set
  assign rd_fast = rd_fast_drv | (pop_on_push & u_dut.push_req);

  uart_cmd_rcv #(.BAUD_DIV(FAST_DIV), .DEPTH(4)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .RX      (rx_fast),
    .rd      (rd_fast),
    .rdy     (rdy_f),
    .rx_data (data_f),
    .frm_err (ferr_f),
    .ovrflw  (ovr_f)
  );

  uart_cmd_rcv #(.BAUD_DIV(SLOW_DIV), .DEPTH(4)) u_slow (
    .clk     (clk),
    .rst     (rst),
    .RX      (rx_slow),
    .rd      (rd_slow),
    .rdy     (rdy_s),
    .rx_data (data_s),
    .frm_err (ferr_s),
    .ovrflw  (ovr_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count high cycles of the status pulses
  initial begin
    ferr_f_cyc = 0;
    ferr_s_cyc = 0;
    ovr_f_cyc  = 0;
  end
  always @(negedge clk) begin
    if (ferr_f) ferr_f_cyc = ferr_f_cyc + 1;
    if (ferr_s) ferr_s_cyc = ferr_s_cyc + 1;
    if (ovr_f)  ovr_f_cyc  = ovr_f_cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed = passed + 1;
  endtask

  task automatic drive_bit(input logic v, input int n, input bit slow);
    if (slow) rx_slow = v;
    else rx_fast = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_head(input logic [7:0] b, input bit slow);
    int div;
    div = slow ? SLOW_DIV : FAST_DIV;
    drive_bit(1'b0, div, slow);
    for (int i = 0; i < 8; i++) drive_bit(b[i], div, slow);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input bit slow);
    send_head(b, slow);
    drive_bit(stop, slow ? SLOW_DIV : FAST_DIV, slow);
  endtask

  task automatic pulse_rd(input bit slow);
    if (slow) rd_slow = 1'b1;
    else rd_fast_drv = 1'b1;
    @(posedge clk);
    #1;
    rd_slow     = 1'b0;
    rd_fast_drv = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] c3;
    logic [7:0] exp_q [4];
    total       = 0;
    passed      = 0;
    rst         = 1'b1;
    rx_fast     = 1'b1;
    rx_slow     = 1'b1;
    rd_fast_drv = 1'b0;
    rd_slow     = 1'b0;
    pop_on_push = 1'b0;

    tbl[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0};
    tbl[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
    tbl[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
    tbl[3] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1};
    tbl[4] = '{8'h55, 1'b1, 1'b1, 8'h55, 0};
    tbl[5] = '{8'h80, 1'b1, 1'b1, 8'h80, 0};
    tbl[6] = '{8'h01, 1'b1, 1'b1, 8'h01, 0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdy",     32'(rdy_f),  32'h0);
    check("rst_rx_data", 32'(data_f), 32'h0);
    check("rst_frm_err", 32'(ferr_f), 32'h0);
    check("rst_ovrflw",  32'(ovr_f),  32'h0);
    check("rst_rdy_slow", 32'(rdy_s), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_bit(1'b1, 2 * FAST_DIV, 1'b0);

    // 0xA5 at full baud divider
    base_ferr = ferr_s_cyc;
    send_head(8'hA5, 1'b1);
    check("slow_rdy_before_stop", 32'(rdy_s), 32'h0);
    drive_bit(1'b1, SLOW_DIV, 1'b1);
    check("slow_rdy", 32'(rdy_s), 32'h1);
    check("slow_data", 32'(data_s), 32'hA5);
    pulse_rd(1'b1);
    check("slow_rdy_after_rd", 32'(rdy_s), 32'h0);

    // Start-bit glitch shorter than half a bit
    drive_bit(1'b0, 1000, 1'b1);
    drive_bit(1'b1, 3000, 1'b1);
    check("glitch_rdy", 32'(rdy_s), 32'h0);
    check("glitch_ferr", 32'(ferr_s_cyc - base_ferr), 32'h0);
    check("glitch_idle", 32'(u_slow.state_q), 32'(seg_uart_pkg::IDLE));

    // Single frames, each read back
    for (int i = 0; i < 7; i++) begin
      base_ferr = ferr_f_cyc;
      send_frame(tbl[i].data, tbl[i].stop, 1'b0);
      drive_bit(1'b1, FAST_DIV, 1'b0);
      check($sformatf("tbl%0d_rdy", i), 32'(rdy_f), 32'(tbl[i].exp_rdy));
      check($sformatf("tbl%0d_ferr", i), 32'(ferr_f_cyc - base_ferr), 32'(tbl[i].exp_ferr));
      if (tbl[i].exp_rdy) begin
        check($sformatf("tbl%0d_data", i), 32'(data_f), 32'(tbl[i].exp_data));
        pulse_rd(1'b0);
        check($sformatf("tbl%0d_rdy_after_rd", i), 32'(rdy_f), 32'h0);
      end
    end

    // Five back-to-back frames into a 4-deep FIFO
    base_ovr = ovr_f_cyc;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0);
    check("b2b_ovr_before_5", 32'(ovr_f_cyc - base_ovr), 32'h0);
    send_frame(8'h05, 1'b1, 1'b0);
    drive_bit(1'b1, FAST_DIV, 1'b0);
    check("b2b_ovr_count", 32'(ovr_f_cyc - base_ovr), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("b2b_rdy%0d", i), 32'(rdy_f), 32'h1);
      check($sformatf("b2b_data%0d", i), 32'(data_f), 32'(i));
      pulse_rd(1'b0);
    end
    check("b2b_empty", 32'(rdy_f), 32'h0);

    // Full FIFO with a pop landing on the push of 0x77
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0);
    drive_bit(1'b1, FAST_DIV, 1'b0);
    base_ovr = ovr_f_cyc;
    pop_on_push = 1'b1;
    send_frame(8'h77, 1'b1, 1'b0);
    pop_on_push = 1'b0;
    drive_bit(1'b1, FAST_DIV, 1'b0);
    check("full_rd_no_ovr", 32'(ovr_f_cyc - base_ovr), 32'h0);
    exp_q[0] = 8'h02;
    exp_q[1] = 8'h03;
    exp_q[2] = 8'h04;
    exp_q[3] = 8'h77;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("full_rd_data%0d", i), 32'(data_f), 32'(exp_q[i]));
      pulse_rd(1'b0);
    end
    check("full_rd_empty", 32'(rdy_f), 32'h0);

    // Reset during data bit 4 of 0xC3 with a byte already queued
    send_frame(8'h42, 1'b1, 1'b0);
    drive_bit(1'b1, FAST_DIV, 1'b0);
    check("pre_rst_rdy", 32'(rdy_f), 32'h1);
    c3 = 8'hC3;
    drive_bit(1'b0, FAST_DIV, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(c3[i], FAST_DIV, 1'b0);
    rx_fast = c3[4];
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_rdy",     32'(rdy_f),  32'h0);
    check("midrst_rx_data", 32'(data_f), 32'h0);
    check("midrst_frm_err", 32'(ferr_f), 32'h0);
    check("midrst_ovrflw",  32'(ovr_f),  32'h0);
    base_ferr = ferr_f_cyc;
    @(posedge clk);
    #1;
    drive_bit(c3[4], 6, 1'b0);
    for (int i = 5; i < 8; i++) drive_bit(c3[i], FAST_DIV, 1'b0);
    drive_bit(1'b1, 3 * FAST_DIV, 1'b0);
    check("midrst_no_byte", 32'(rdy_f), 32'h0);
    check("midrst_no_ferr", 32'(ferr_f_cyc - base_ferr), 32'h0);
    send_frame(8'h9E, 1'b1, 1'b0);
    drive_bit(1'b1, FAST_DIV, 1'b0);
    check("post_rst_rdy", 32'(rdy_f), 32'h1);
    check("post_rst_data", 32'(data_f), 32'h9E);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
